// File: rtl/denoise_pkg.sv
// Shared constants, state encoding and helpers for the temporal blend stage.
package denoise_pkg;

    localparam int CH_W      = 10;
    localparam int ALPHA_W   = 5;
    localparam int ALPHA_ONE = 16;
    localparam int NUM_CH    = 3;
    localparam int PROD_W    = CH_W + ALPHA_W;
    localparam int STAGES    = 2;

    localparam int R_LSB = 20;
    localparam int B_LSB = 10;
    localparam int G_LSB = 0;

    typedef enum logic {
        SEEK = 1'b0,
        RUN  = 1'b1
    } blend_state_e;

    // Channel index to bit offset: 0 = G, 1 = B, 2 = R.
    function automatic int ch_lsb(input int c);
        case (c)
            0:       return G_LSB;
            1:       return B_LSB;
            default: return R_LSB;
        endcase
    endfunction

    function automatic logic [ALPHA_W-1:0] clamp_alpha(input logic [ALPHA_W-1:0] a);
        return (a > ALPHA_W'(ALPHA_ONE)) ? ALPHA_W'(ALPHA_ONE) : a;
    endfunction

endpackage

// File: rtl/blend_ch.sv
// One 10-bit channel of the temporal blend: stage 1 weights, stage 2 sums and scales.
// TEMPORAL_BLEND_MOTION_EN adds the per-channel motion compare.
module blend_ch
    import denoise_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               en,
    input  logic [ALPHA_W-1:0] alpha,
    input  logic               bypass,
    input  logic [CH_W-1:0]    filt,
    input  logic [CH_W-1:0]    prev,
`ifdef TEMPORAL_BLEND_MOTION_EN
    input  logic [CH_W-1:0]    motion_thresh,
    output logic               motion,
`endif
    output logic [CH_W-1:0]    pix
);

    logic [ALPHA_W-1:0] alpha_inv;
    logic [PROD_W-1:0]  a_q, b_q;
    logic [CH_W-1:0]    filt_q;
    logic               byp_q;
    logic [CH_W-1:0]    avg;
    logic               unused_msb;
    logic [3:0]         unused_frac;

    assign alpha_inv = ALPHA_W'(ALPHA_ONE) - alpha;

`ifdef TEMPORAL_BLEND_MOTION_EN
    logic [CH_W-1:0] diff;
    assign diff   = (filt >= prev) ? (filt - prev) : (prev - filt);
    assign motion = diff > motion_thresh;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            a_q    <= '0;
            b_q    <= '0;
            filt_q <= '0;
            byp_q  <= 1'b0;
        end else if (en) begin
            a_q    <= PROD_W'(alpha) * PROD_W'(filt);
            b_q    <= PROD_W'(alpha_inv) * PROD_W'(prev);
            filt_q <= filt;
            byp_q  <= bypass;
        end
    end

    // Weights sum to 16, so the sum never exceeds 16368 and >>4 fits 10 bits.
    assign {unused_msb, avg, unused_frac} = a_q + b_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pix <= '0;
        end else if (en) begin
            pix <= byp_q ? filt_q : avg;
        end
    end

endmodule

// File: rtl/temporal_blend.sv
// Joins filtered and previous-frame streams, realigns on SOF and emits a
// recursive temporal average. TEMPORAL_BLEND_MOTION_EN enables motion override.
module temporal_blend
    import denoise_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [DATA_WIDTH-1:0] s_filt_axis_tdata,
    input  logic                  s_filt_axis_tvalid,
    output logic                  s_filt_axis_tready,
    input  logic                  s_filt_axis_tlast,
    input  logic                  s_filt_axis_tuser,

    input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
    input  logic                  s_prev_axis_tvalid,
    output logic                  s_prev_axis_tready,
    input  logic                  s_prev_axis_tlast,
    input  logic                  s_prev_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    input  logic [4:0]            alpha,
    input  logic                  bypass,
    input  logic [9:0]            motion_thresh,
    output logic [CNT_WIDTH-1:0]  resync_cnt
);

    blend_state_e state_q, state_d;

    logic adv, f_v, p_v, f_u, p_u;
    logic sof_pair, mismatch;
    logic f_rdy, p_rdy, pair_acc, resync_inc, sof_acc;

    logic [ALPHA_W-1:0] alpha_l, alpha_frame, alpha_use;
    logic               bypass_l, bypass_frame;

    logic [STAGES:0] vld_pipe, user_pipe, last_pipe;

    logic [NUM_CH-1:0][CH_W-1:0] pix;

    assign f_v = s_filt_axis_tvalid;
    assign p_v = s_prev_axis_tvalid;
    assign f_u = s_filt_axis_tuser;
    assign p_u = s_prev_axis_tuser;

    assign adv      = !m_axis_tvalid || m_axis_tready;
    assign sof_pair = f_v && p_v && f_u && p_u;
    assign mismatch = f_v && p_v && (f_u != p_u);

    // Join control: SEEK discards non-SOF heads independently, RUN moves pairs only.
    always_comb begin
        state_d    = state_q;
        f_rdy      = 1'b0;
        p_rdy      = 1'b0;
        pair_acc   = 1'b0;
        resync_inc = 1'b0;
        if (aresetn && adv) begin
            case (state_q)
                SEEK: begin
                    f_rdy    = !f_u || sof_pair;
                    p_rdy    = !p_u || sof_pair;
                    pair_acc = sof_pair;
                    if (sof_pair) state_d = RUN;
                end
                RUN: begin
                    if (mismatch) begin
                        state_d    = SEEK;
                        resync_inc = 1'b1;
                    end else begin
                        f_rdy    = p_v;
                        p_rdy    = f_v;
                        pair_acc = f_v && p_v;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    assign s_filt_axis_tready = f_rdy;
    assign s_prev_axis_tready = p_rdy;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= SEEK;
            resync_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (resync_inc && resync_cnt != '1) resync_cnt <= resync_cnt + 1'b1;
        end
    end

    // The SOF pixel itself already uses the new frame's controls.
    assign sof_acc      = pair_acc && f_u;
    assign alpha_frame  = sof_acc ? clamp_alpha(alpha) : alpha_l;
    assign bypass_frame = sof_acc ? bypass : bypass_l;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            alpha_l  <= ALPHA_W'(ALPHA_ONE);
            bypass_l <= 1'b0;
        end else if (sof_acc) begin
            alpha_l  <= alpha_frame;
            bypass_l <= bypass_frame;
        end
    end

`ifdef TEMPORAL_BLEND_MOTION_EN
    logic [NUM_CH-1:0] motion_vec;
    assign alpha_use = (|motion_vec) ? ALPHA_W'(ALPHA_ONE) : alpha_frame;
`else
    assign alpha_use = alpha_frame;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int LSB = ch_lsb(c);
        blend_ch u_ch (
            .aclk          (aclk),
            .aresetn       (aresetn),
            .en            (adv),
            .alpha         (alpha_use),
            .bypass        (bypass_frame),
            .filt          (s_filt_axis_tdata[LSB +: CH_W]),
            .prev          (s_prev_axis_tdata[LSB +: CH_W]),
`ifdef TEMPORAL_BLEND_MOTION_EN
            .motion_thresh (motion_thresh),
            .motion        (motion_vec[c]),
`endif
            .pix           (pix[c])
        );
    end

    // Sideband follows filt and shifts in lockstep with the datapath.
    assign vld_pipe[0]  = pair_acc;
    assign user_pipe[0] = f_u;
    assign last_pipe[0] = s_filt_axis_tlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld_pipe[STAGES:1]  <= '0;
            user_pipe[STAGES:1] <= '0;
            last_pipe[STAGES:1] <= '0;
        end else if (adv) begin
            vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
            user_pipe[STAGES:1] <= user_pipe[STAGES-1:0];
            last_pipe[STAGES:1] <= last_pipe[STAGES-1:0];
        end
    end

    assign m_axis_tvalid = vld_pipe[STAGES];
    assign m_axis_tuser  = user_pipe[STAGES];
    assign m_axis_tlast  = last_pipe[STAGES];
    assign m_axis_tdata  = {{(DATA_WIDTH-NUM_CH*CH_W){1'b0}}, pix};

    logic unused_inputs;
`ifdef TEMPORAL_BLEND_MOTION_EN
    assign unused_inputs = ^{s_prev_axis_tlast,
                             s_filt_axis_tdata[DATA_WIDTH-1:NUM_CH*CH_W],
                             s_prev_axis_tdata[DATA_WIDTH-1:NUM_CH*CH_W]};
`else
    assign unused_inputs = ^{s_prev_axis_tlast, motion_thresh,
                             s_filt_axis_tdata[DATA_WIDTH-1:NUM_CH*CH_W],
                             s_prev_axis_tdata[DATA_WIDTH-1:NUM_CH*CH_W]};
`endif

endmodule

// File: tb/tb_temporal_blend.sv
// Randomized bench for temporal_blend against a transaction-level join/blend model.
module tb_temporal_blend;

    localparam int BUDGET = 4000;

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        aclk = 0, aresetn = 0;
    logic [31:0] f_tdata = 0, p_tdata = 0, m_tdata;
    logic        f_tvalid = 0, f_tready, f_tlast = 0, f_tuser = 0;
    logic        p_tvalid = 0, p_tready, p_tlast = 0, p_tuser = 0;
    logic        m_tvalid, m_tready = 1, m_tlast, m_tuser;
    logic [4:0]  alpha = 16;
    logic        bypass = 0;
    logic [9:0]  motion_thresh = 10'h3FF;
    logic [15:0] resync_cnt;

    int n_checks = 0, n_fail = 0;

    beat_t fq[$], pq[$], exp_q[$], got[$];

    // Reference model state: join mode, resync count, frame controls.
    bit m_run = 0;
    int m_cnt = 0, m_alpha = 16;
    bit m_byp = 0;

    logic [31:0] snap_d;
    logic        snap_v;
    logic [31:0] stall_d[4];
    logic        stall_v[4], stall_r[4];

    temporal_blend dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_filt_axis_tdata(f_tdata), .s_filt_axis_tvalid(f_tvalid), .s_filt_axis_tready(f_tready),
        .s_filt_axis_tlast(f_tlast), .s_filt_axis_tuser(f_tuser),
        .s_prev_axis_tdata(p_tdata), .s_prev_axis_tvalid(p_tvalid), .s_prev_axis_tready(p_tready),
        .s_prev_axis_tlast(p_tlast), .s_prev_axis_tuser(p_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .alpha(alpha), .bypass(bypass), .motion_thresh(motion_thresh), .resync_cnt(resync_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] blend(input logic [31:0] f, input logic [31:0] p,
                                          input int a, input bit byp);
        logic [31:0] r = 0;
        int w = a;
        if (byp) return {2'b00, f[29:0]};
`ifdef TEMPORAL_BLEND_MOTION_EN
        for (int c = 0; c < 3; c++) begin
            int fc = int'(f[c*10 +: 10]), pc = int'(p[c*10 +: 10]);
            int dd = (fc > pc) ? fc - pc : pc - fc;
            if (dd > int'(motion_thresh)) w = 16;
        end
`endif
        for (int c = 0; c < 3; c++)
            r[c*10 +: 10] = 10'((w * int'(f[c*10 +: 10]) + (16 - w) * int'(p[c*10 +: 10])) / 16);
        return r;
    endfunction

    // Sequence-level join: SEEK drops non-SOF heads, RUN pairs equal-tuser heads.
    function automatic void model_run();
        int i = 0, j = 0;
        exp_q.delete();
        while (i < fq.size() && j < pq.size()) begin
            beat_t e;
            if (!m_run) begin
                if (!fq[i].u) begin i++; continue; end
                if (!pq[j].u) begin j++; continue; end
                m_run = 1;
            end else if (fq[i].u != pq[j].u) begin
                m_run = 0;
                if (m_cnt < 65535) m_cnt++;
                continue;
            end
            if (fq[i].u) begin
                m_alpha = (alpha > 16) ? 16 : int'(alpha);
                m_byp   = bypass;
            end
            e.d = blend(fq[i].d, pq[j].d, m_alpha, m_byp);
            e.u = fq[i].u;
            e.l = fq[i].l;
            exp_q.push_back(e);
            i++; j++;
        end
    endfunction

    function automatic beat_t rnd_beat(input bit sof, input int idx);
        beat_t b;
        b.d = $urandom;
        b.u = sof;
        b.l = (idx % 8 == 7);
        return b;
    endfunction

    function automatic void push_frame(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(rnd_beat(i == 0, i));
            pq.push_back(rnd_beat(i == 0, i));
        end
    endfunction

    task automatic drive_filt(input int gap);
        int idx = 0, cyc = 0;
        bit fired = 0;
        while (idx < fq.size()) begin
            @(negedge aclk);
            if (fired) begin f_tvalid = 0; fired = 0; end
            if (!f_tvalid && $urandom_range(99) >= gap) begin
                f_tvalid = 1; f_tdata = fq[idx].d; f_tuser = fq[idx].u; f_tlast = fq[idx].l;
            end
            #1;
            if (f_tvalid && f_tready) begin idx++; fired = 1; end
            cyc++;
            if (cyc > BUDGET) begin
                n_checks++; n_fail++;
                $display("FAIL filt_drain: consumed %0d of %0d beats", idx, fq.size());
                break;
            end
        end
        @(negedge aclk);
        f_tvalid = 0;
    endtask

    task automatic drive_prev(input int gap);
        int idx = 0, cyc = 0;
        bit fired = 0;
        while (idx < pq.size()) begin
            @(negedge aclk);
            if (fired) begin p_tvalid = 0; fired = 0; end
            if (!p_tvalid && $urandom_range(99) >= gap) begin
                p_tvalid = 1; p_tdata = pq[idx].d; p_tuser = pq[idx].u; p_tlast = pq[idx].l;
            end
            #1;
            if (p_tvalid && p_tready) begin idx++; fired = 1; end
            cyc++;
            if (cyc > BUDGET) begin
                n_checks++; n_fail++;
                $display("FAIL prev_drain: consumed %0d of %0d beats", idx, pq.size());
                break;
            end
        end
        @(negedge aclk);
        p_tvalid = 0;
    endtask

    task automatic collect(input int n, input int rdy, input int stall_at);
        int cyc = 0;
        got.delete();
        while (got.size() < n) begin
            @(negedge aclk);
            if (stall_at >= 0 && got.size() == stall_at) begin
                m_tready = 0;
                #1; snap_v = m_tvalid; snap_d = m_tdata;
                for (int k = 0; k < 4; k++) begin
                    @(negedge aclk); #1;
                    stall_v[k] = m_tvalid; stall_d[k] = m_tdata; stall_r[k] = f_tready | p_tready;
                end
                stall_at = -1;
                continue;
            end
            m_tready = ($urandom_range(99) < rdy);
            #1;
            if (m_tvalid && m_tready) begin
                beat_t b;
                b.d = m_tdata; b.u = m_tuser; b.l = m_tlast;
                got.push_back(b);
            end
            cyc++;
            if (cyc > BUDGET) begin
                n_checks++; n_fail++;
                $display("FAIL out_count: got %0d beats, expected %0d", got.size(), n);
                break;
            end
        end
        @(negedge aclk);
        m_tready = 1;
    endtask

    task automatic run_frame(input int gap, input int rdy, input int stall_at);
        model_run();
        fork
            drive_filt(gap);
            drive_prev(gap);
            collect(exp_q.size(), rdy, stall_at);
        join
    endtask

    task automatic test_reset();
        f_tvalid = 1; p_tvalid = 1; f_tdata = $urandom; p_tdata = $urandom;
        repeat (3) @(negedge aclk);
        #1;
        n_checks++;
        if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== 35'h0) begin
            n_fail++; $display("FAIL reset_out: got v%b u%b l%b d%h, expected all 0", m_tvalid, m_tuser, m_tlast, m_tdata);
        end
        n_checks++;
        if (resync_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", resync_cnt); end
        n_checks++;
        if ({f_tready, p_tready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {f_tready, p_tready}); end
        @(negedge aclk);
        aresetn = 1; f_tvalid = 0; p_tvalid = 0;
        m_run = 0; m_cnt = 0; m_alpha = 16; m_byp = 0;
    endtask

    task automatic test_seek_discard();
        fq.delete(); pq.delete();
        for (int i = 0; i < 3; i++) pq.push_back(rnd_beat(0, i));
        alpha = 5'($urandom_range(0, 16)); bypass = 0;
        push_frame(20);
        run_frame(20, 80, -1);
        n_checks++;
        if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL seek_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({got[i].u, got[i].l, got[i].d} !== {exp_q[i].u, exp_q[i].l, exp_q[i].d}) begin
                n_fail++; $display("FAIL seek_beat %0d: got %b%b %h expected %b%b %h", i, got[i].u, got[i].l, got[i].d, exp_q[i].u, exp_q[i].l, exp_q[i].d);
            end
        end
        n_checks++;
        if (got.size() == 0 || got[0].u !== 1'b1) begin n_fail++; $display("FAIL seek_first_sof: first output tuser not 1"); end
        n_checks++;
        if (resync_cnt !== 16'd0) begin n_fail++; $display("FAIL seek_cnt: got %0d expected 0", resync_cnt); end
    endtask

    task automatic test_blend_values();
        logic [31:0] fv[3], pv[3], ev[3];
        int av[3];
        fv[0] = 32'h3FF003FF; pv[0] = 32'h0;                 av[0] = 16; ev[0] = 32'h3FF003FF;
        fv[1] = $urandom;     pv[1] = $urandom;              av[1] = 0;  ev[1] = {2'b00, pv[1][29:0]};
        fv[2] = 32'h3FF00000; pv[2] = 32'h00100000;          av[2] = 8;  ev[2] = 32'h20000000;
        motion_thresh = 10'h3FF; bypass = 0;
        for (int t = 0; t < 3; t++) begin
            beat_t b;
            fq.delete(); pq.delete();
            alpha = 5'(av[t]);
            b.d = fv[t]; b.u = 1; b.l = 1; fq.push_back(b);
            b.d = pv[t]; pq.push_back(b);
            run_frame(0, 100, -1);
            n_checks++;
            if (got.size() != 1 || got[0].d !== ev[t] || exp_q[0].d !== ev[t]) begin
                n_fail++; $display("FAIL blend_const %0d: got %h expected %h", t, (got.size() > 0) ? got[0].d : 32'hx, ev[t]);
            end
        end
    endtask

    task automatic test_random();
        for (int fr = 0; fr < 6; fr++) begin
            fq.delete(); pq.delete();
            alpha = 5'($urandom_range(0, 20));
            bypass = ($urandom_range(0, 3) == 0);
            motion_thresh = 10'($urandom_range(0, 600));
            push_frame($urandom_range(1, 60));
            run_frame($urandom_range(0, 40), $urandom_range(50, 100), -1);
            n_checks++;
            if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count fr%0d: got %0d expected %0d", fr, got.size(), exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if ({got[i].u, got[i].l, got[i].d} !== {exp_q[i].u, exp_q[i].l, exp_q[i].d}) begin
                    n_fail++; $display("FAIL rand_beat fr%0d/%0d: got %b%b %h expected %b%b %h", fr, i, got[i].u, got[i].l, got[i].d, exp_q[i].u, exp_q[i].l, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic test_stall();
        fq.delete(); pq.delete();
        alpha = 5'($urandom_range(0, 16)); bypass = 0;
        push_frame(30);
        run_frame(0, 100, 10);
        n_checks++;
        if (snap_v !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", snap_v); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({stall_v[k], stall_d[k], stall_r[k]} !== {snap_v, snap_d, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold %0d: got v%b d%h rdy%b expected v%b d%h rdy0", k, stall_v[k], stall_d[k], stall_r[k], snap_v, snap_d);
            end
        end
        n_checks++;
        if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({got[i].u, got[i].l, got[i].d} !== {exp_q[i].u, exp_q[i].l, exp_q[i].d}) begin
                n_fail++; $display("FAIL stall_beat %0d: got %h expected %h", i, got[i].d, exp_q[i].d);
            end
        end
    endtask

    task automatic test_resync();
        fq.delete(); pq.delete();
        alpha = 5'($urandom_range(0, 16)); bypass = 0;
        for (int i = 0; i < 100; i++) begin fq.push_back(rnd_beat(i == 0, i)); pq.push_back(rnd_beat(i == 0, i)); end
        for (int i = 0; i < 3; i++) pq.push_back(rnd_beat(0, 100 + i));
        push_frame(40);
        run_frame(15, 85, -1);
        n_checks++;
        if (resync_cnt !== 16'(m_cnt) || m_cnt != 1) begin n_fail++; $display("FAIL resync_cnt: got %0d expected 1", resync_cnt); end
        n_checks++;
        if (got.size() !== 140) begin n_fail++; $display("FAIL resync_count: got %0d expected 140", got.size()); end
        n_checks++;
        if (got.size() > 100 && got[100].u !== 1'b1) begin n_fail++; $display("FAIL resync_sof: output 100 tuser %b expected 1", got[100].u); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({got[i].u, got[i].l, got[i].d} !== {exp_q[i].u, exp_q[i].l, exp_q[i].d}) begin
                n_fail++; $display("FAIL resync_beat %0d: got %b %h expected %b %h", i, got[i].u, got[i].d, exp_q[i].u, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] fd, pd, ed;
        m_tready = 1; alpha = 16; bypass = 0;
        @(negedge aclk);
        f_tvalid = 1; f_tuser = 1; f_tlast = 0; f_tdata = $urandom;
        p_tvalid = 1; p_tuser = 1; p_tlast = 0; p_tdata = $urandom;
        #1;
        n_checks++;
        if ({f_tready, p_tready} !== 2'b11) begin n_fail++; $display("FAIL mid_accept: ready %b expected 11", {f_tready, p_tready}); end
        @(negedge aclk);
        f_tvalid = 0; p_tvalid = 0; aresetn = 0;
        @(negedge aclk); #1;
        n_checks++;
        if ({m_tvalid, resync_cnt} !== 17'h0) begin n_fail++; $display("FAIL mid_flush: v%b cnt %0d expected v0 cnt 0", m_tvalid, resync_cnt); end
        aresetn = 1;
        m_run = 0; m_cnt = 0; m_alpha = 16; m_byp = 0;
        @(negedge aclk); #1;
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got v%b expected 0", m_tvalid); end
        fd = $urandom; pd = $urandom; alpha = 5;
        ed = blend(fd, pd, 5, 0);
        @(negedge aclk);
        f_tvalid = 1; f_tuser = 1; f_tlast = 1; f_tdata = fd;
        p_tvalid = 1; p_tuser = 1; p_tlast = 0; p_tdata = pd;
        #1;
        n_checks++;
        if ({f_tready, p_tready} !== 2'b11) begin n_fail++; $display("FAIL post_sof_accept: ready %b expected 11", {f_tready, p_tready}); end
        m_run = 1; m_alpha = 5;
        @(negedge aclk);
        f_tvalid = 0; p_tvalid = 0;
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL post_sof_early: got v%b expected 0", m_tvalid); end
        @(negedge aclk); #1;
        n_checks++;
        if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== {3'b111, ed}) begin
            n_fail++; $display("FAIL post_sof_out: got v%b u%b l%b %h expected v1 u1 l1 %h", m_tvalid, m_tuser, m_tlast, m_tdata, ed);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL post_sof_once: got v%b expected 0", m_tvalid); end
    endtask

    initial begin
        test_reset();
        test_seek_discard();
        test_blend_values();
        test_random();
        test_stall();
        test_resync();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/temporal_blend.md
Name: temporal_blend

Overview:
- Stage directly downstream of the spatial denoise core; sits between the core's master stream and the output/VDMA write path.
- Joins the spatially filtered current frame (s_filt) with the previous output frame read back from memory (s_prev), pixel by pixel.
- Produces a recursive temporal average: out = (alpha*filt + (16-alpha)*prev) >> 4 per 10-bit channel.
- Re-aligns the two streams on start-of-frame (tuser) and counts realignment events.

Parameters:
- DATA_WIDTH, 32, stream width; pixel is {2'b0, R[29:20], B[19:10], G[9:0]}.
- CNT_WIDTH, 16, width of resync_cnt.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_filt_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  filtered current stream
- s_prev_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  previous-frame stream
- m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  blended output
- alpha  in  5  weight of filt, 0..16; values >16 are clamped to 16
- bypass  in  1  output filt data unchanged
- motion_thresh  in  10  per-channel motion threshold (used only with the optional feature)
- resync_cnt  out  CNT_WIDTH  saturating count of mid-frame misalignments

Behaviour:
- Reset: all outputs 0. Pipeline valids cleared, state SEEK, resync_cnt 0, latched alpha 16, latched bypass 0.
- adv = !m_axis_tvalid || m_axis_tready. The pipeline and all input acceptance advance only when adv is high.
- Pair transfer: both tvalid high and both tready high in the same cycle. The two inputs are never consumed independently, except for discards in SEEK.
- State SEEK:
  - Each input is ready (adv && its tuser==0) and discards its head beat while tuser==0.
  - An input whose head beat has tuser=1 is stalled.
  - When both heads are valid with tuser=1 and adv=1: pair transfer, go to RUN.
  - Discards in SEEK never increment resync_cnt.
- State RUN:
  - s_filt_tready = adv && s_prev_tvalid; s_prev_tready = adv && s_filt_tvalid.
  - Pair with equal tuser (both 0 or both 1): transfer, stay in RUN.
  - Both valid with exactly one tuser=1: no transfer, go to SEEK, resync_cnt += 1 (saturates at all-ones).
- Frame controls: alpha (clamped) and bypass are latched on every accepted pair with tuser=1 and hold for the whole frame.
- Datapath, per channel c:
  - Stage 1 registers a = alpha_l*filt_c and b = (16-alpha_l)*prev_c (15 bits each).
  - Stage 2 registers (a+b)>>4. Maximum 16368>>4 = 1023, so there is no overflow and no rounding.
  - Output bits 31:30 are 0.
- Bypass: stage 2 outputs filt data verbatim (bits 29:0; 31:30 forced 0). prev is still consumed in pairs.
- Sideband: tuser and tlast are taken from s_filt and delayed with the data. s_prev tlast is ignored.
- Latency: a pair accepted at edge N appears on m_axis at edge N+2 (with no stall).
- Stall: when adv=0, all pipeline registers and m_axis_* hold. No beat is lost or duplicated.
- Reset mid-operation: the pipeline is flushed; in-flight beats are dropped; state returns to SEEK.

Optional Feature:
- Macro: TEMPORAL_BLEND_MOTION_EN.
- Defined: per pixel, if |filt_c - prev_c| > motion_thresh for any channel, that pixel uses alpha 16 (filt only). The compare is done in stage 1; latency is unchanged.
- Undefined: motion_thresh is ignored and no compare logic is built.

Decomposition:
- Package denoise_pkg:
  - CH_W=10, ALPHA_W=5, ALPHA_ONE=16.
  - Channel bit-offset constants R_LSB=20, B_LSB=10, G_LSB=0.
  - Blend state enum {SEEK, RUN}.
- Sub-module blend_ch: one channel's two-stage multiply/add/shift with a stall enable (plus the motion compare under the macro); instantiated 3x.
- Join/FSM/sideband logic stays in the top level.

Test Plan:
- alpha=16, filt=0x3FF003FF, prev=0 -> out 0x3FF003FF. alpha=0 -> out equals prev. alpha=8, filt R=0x3FF, prev R=0x001 -> out R=0x200.
- Hold m_axis_tready low 5 cycles mid-line with both inputs streaming -> m_axis held stable, both treadys low; after release, beat order is intact and the count is exact.
- prev presents 3 non-tuser beats before its SOF; filt starts on SOF -> 3 prev beats discarded, first output has tuser=1 and blends the two SOF pixels, resync_cnt stays 0.
- In RUN, filt asserts tuser at pixel 100 while prev does not -> resync_cnt=1, state SEEK, prev drained until its tuser, output resumes with tuser=1.
- Assert aresetn=0 for 1 cycle with valid data in flight -> next cycle m_axis_tvalid=0, resync_cnt=0. Next SOF pair is output 2 cycles after acceptance.
- With TEMPORAL_BLEND_MOTION_EN: motion_thresh=16, alpha=4, filt G=100, prev G=50 -> out G=100. With filt G=60, prev G=50 -> out G=(240+600)>>4=52.
